// File: rtl/adc128_reader.sv
// ADC128S022 SPI front-end: alternately converts the hotend and bed channels and
// presents a per-channel average of 2^AVG_LOG2 samples with an update strobe.
module adc128_reader #(
  parameter int         DIV         = 16,
  parameter logic [2:0] ADDR_HOTEND = 3'd0,
  parameter logic [2:0] ADDR_BED    = 3'd1,
  parameter int         AVG_LOG2    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [11:0] adc_hotend,
  output logic [11:0] adc_bed,
  output logic        hotend_strobe,
  output logic        bed_strobe,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = $clog2(2 * DIV);
  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int NUM_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * DIV - 1);
  localparam logic [NUM_W-1:0] NUM_LAST  = NUM_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_q;
  logic             cs_n_q;
  logic             sclk_q;
  logic             din_q;
  logic [1:0]       sync_q;
  // Only the low 12 bits of the received word carry conversion data.
  logic [11:0]      shift_q;
  logic             first_q;
  logic             next_bed_q;
  logic             prev_bed_q;
  logic [ACC_W-1:0] acc_q [2];
  logic [NUM_W-1:0] num_q [2];
  logic [11:0]      out_q [2];
  logic             hot_stb_q;
  logic             bed_stb_q;

  logic [15:0]      din_word;
  logic [3:0]       bit_nx;
  logic [ACC_W-1:0] sum_d;

  assign din_word = {2'b00, (next_bed_q ? ADDR_BED : ADDR_HOTEND), 11'd0};
  assign bit_nx   = bit_q + 4'd1;
  assign sum_d    = acc_q[prev_bed_q] + ACC_W'(shift_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b1;
      din_q      <= 1'b0;
      sync_q     <= '0;
      shift_q    <= '0;
      first_q    <= 1'b0;
      next_bed_q <= 1'b0;
      prev_bed_q <= 1'b0;
      hot_stb_q  <= 1'b0;
      bed_stb_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        acc_q[i] <= '0;
        num_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      sync_q    <= {sync_q[0], adc_dout};
      hot_stb_q <= 1'b0;
      bed_stb_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q    <= S_FRAME;
            cs_n_q     <= 1'b0;
            sclk_q     <= 1'b0;
            din_q      <= 1'b0;
            cnt_q      <= '0;
            bit_q      <= '0;
            first_q    <= 1'b1;
            next_bed_q <= 1'b0;
          end
        end
        S_FRAME: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // Last clock of the high half: take the bit, then fall or end the frame.
              shift_q <= {shift_q[10:0], sync_q[1]};
              if (bit_q == 4'd15) begin
                state_q <= S_GAP;
                cs_n_q  <= 1'b1;
              end else begin
                bit_q  <= bit_nx;
                sclk_q <= 1'b0;
                din_q  <= din_word[~bit_nx];
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            if (first_q) begin
              first_q <= 1'b0;
            end else if (num_q[prev_bed_q] == NUM_LAST) begin
              out_q[prev_bed_q] <= sum_d[ACC_W-1:AVG_LOG2];
              acc_q[prev_bed_q] <= '0;
              num_q[prev_bed_q] <= '0;
              hot_stb_q         <= !prev_bed_q;
              bed_stb_q         <= prev_bed_q;
            end else begin
              acc_q[prev_bed_q] <= sum_d;
              num_q[prev_bed_q] <= num_q[prev_bed_q] + NUM_W'(1);
            end
            prev_bed_q <= next_bed_q;
            next_bed_q <= !next_bed_q;
          end
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (enable) begin
              state_q <= S_FRAME;
              cs_n_q  <= 1'b0;
              sclk_q  <= 1'b0;
              din_q   <= din_word[15];
              bit_q   <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adc_cs_n      = cs_n_q;
  assign adc_sclk      = sclk_q;
  assign adc_din       = din_q;
  assign adc_hotend    = out_q[0];
  assign adc_bed       = out_q[1];
  assign hotend_strobe = hot_stb_q;
  assign bed_strobe    = bed_stb_q;
  assign dbg_state     = state_q;

endmodule
